// File: rtl/fifo_rd_pkg.sv
// Shared widths, skid-buffer depth and the buffer-level helper for the FIFO stream reader.
package fifo_rd_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 36;
    localparam int unsigned CNT_WIDTH_DEF  = 16;
    localparam int unsigned SKID_DEPTH     = 2;
    localparam int unsigned OCC_WIDTH      = $clog2(SKID_DEPTH + 1);
    localparam int unsigned LVL_WIDTH      = OCC_WIDTH + 1;

    // Buffer occupancy at the next edge: held words plus the arriving word minus the departing one.
    function automatic logic [LVL_WIDTH-1:0] next_level(
        input logic [OCC_WIDTH-1:0] occ,
        input logic                 inflight,
        input logic                 pop
    );
        return LVL_WIDTH'(occ) + LVL_WIDTH'(inflight) - LVL_WIDTH'(pop);
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order skid buffer; entry 0 is always the oldest word.
module skid_buf2 import fifo_rd_pkg::*; #(
    parameter int unsigned DW = DATA_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DW-1:0]        push_data_i,
    input  logic                 pop_i,
    output logic                 valid_o,
    output logic [DW-1:0]        data_o,
    output logic [OCC_WIDTH-1:0] occ_o
);

    logic [DW-1:0]        mem_q [SKID_DEPTH];
    logic [DW-1:0]        mem_d [SKID_DEPTH];
    logic [OCC_WIDTH-1:0] occ_q;
    logic [OCC_WIDTH-1:0] occ_d;
    logic                 pop_ok;
    logic [OCC_WIDTH-1:0] occ_rem;

    // Pop shifts the queue forward first, so a same-cycle push lands behind the survivors.
    always_comb begin
        mem_d   = mem_q;
        occ_d   = occ_q;
        pop_ok  = pop_i && (occ_q != '0);
        occ_rem = occ_q - OCC_WIDTH'(pop_ok);
        if (pop_ok) begin
            for (int unsigned i = 0; i < SKID_DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
        end
        if (push_i && (occ_rem < OCC_WIDTH'(SKID_DEPTH))) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                if (OCC_WIDTH'(i) == occ_rem) begin
                    mem_d[i] = push_data_i;
                end
            end
            occ_d = occ_rem + OCC_WIDTH'(1);
        end else begin
            occ_d = occ_rem;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            mem_q <= mem_d;
            occ_q <= occ_d;
        end
    end

    assign valid_o = (occ_q != '0);
    assign data_o  = mem_q[0];
    assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pulls words from a FIFO with one-cycle read latency and presents them as a valid/ready stream.
module fifo_stream_reader import fifo_rd_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clock0,
    input  logic                  rst_ptr_n,
    input  logic                  en,
    input  logic                  EMPTY,
    input  logic                  EPO,
    input  logic                  UNDERRUN,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  re,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  err_underrun
);

    logic                 inflight_q, inflight_d;
    logic                 empty_q, empty_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] words_q, words_d;
    logic                 pop;
    logic [OCC_WIDTH-1:0] occ;
    logic [LVL_WIDTH-1:0] level;

    skid_buf2 #(
        .DW (DATA_WIDTH)
    ) u_skid (
        .clk_i       (clock0),
        .rst_ni      (rst_ptr_n),
        .push_i      (inflight_q),
        .push_data_i (fifo_dout),
        .pop_i       (pop),
        .valid_o     (m_valid),
        .data_o      (m_data),
        .occ_o       (occ)
    );

    assign pop   = m_valid & m_ready;
    assign level = next_level(occ, inflight_q, pop);

    // EPO with a read in flight means the FIFO flags have not yet seen that read: it is really empty.
    always_comb begin
        re = rst_ptr_n & en & ~EMPTY & ~(inflight_q & EPO)
           & (level < LVL_WIDTH'(SKID_DEPTH));
    end

    always_comb begin
        inflight_d = re;
        empty_d    = EMPTY;
        err_d      = err_q | UNDERRUN | (inflight_q & empty_q);
        words_d    = words_q;
        if (pop) begin
            words_d = words_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock0 or negedge rst_ptr_n) begin
        if (!rst_ptr_n) begin
            inflight_q <= 1'b0;
            empty_q    <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            empty_q    <= empty_d;
            err_q      <= err_d;
            words_q    <= words_d;
        end
    end

    assign words_out    = words_q;
    assign err_underrun = err_q;

endmodule
